// File: rtl/rv32_pkg.sv
// Shared RV32I encoding types: instruction formats, base opcodes and the
// decoded-field descriptor consumed by id_encoder.
package rv32_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

endpackage

// File: rtl/id_imm_pack.sv
// Scatters an immediate into instruction bits [31:7] for its format and
// flags immediates the format cannot represent (or an illegal format).
module id_imm_pack
  import rv32_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:7] imm_bits,
  output logic [31:7] imm_mask,
  output logic        imm_err
);

  // Per-format scatter of immediate bits plus representability check.
  always_comb begin
    imm_bits = 25'd0;
    imm_mask = 25'd0;
    imm_err  = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: begin
        imm_err = 1'b0;
      end
      FMT_I: begin
        imm_bits[31:20] = imm[11:0];
        imm_mask[31:20] = 12'hFFF;
        imm_err         = (imm != {{20{imm[11]}}, imm[11:0]});
      end
      FMT_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        imm_mask[31:25] = 7'h7F;
        imm_mask[11:7]  = 5'h1F;
        imm_err         = (imm != {{20{imm[11]}}, imm[11:0]});
      end
      FMT_B: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        imm_mask[31:25] = 7'h7F;
        imm_mask[11:7]  = 5'h1F;
        imm_err         = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
      end
      FMT_U: begin
        imm_bits[31:12] = imm[31:12];
        imm_mask[31:12] = 20'hFFFFF;
        imm_err         = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        imm_mask[31:12] = 20'hFFFFF;
        imm_err         = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
      end
      default: begin
        imm_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_encoder.sv
// Streaming RV32I encoder: one descriptor per handshake into a single-entry
// output register, tagged with a sequential word address and error flags.
module id_encoder
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  enc_req_t          req_s;
  logic [31:7]       imm_bits_s;
  logic [31:7]       imm_mask_s;
  logic              imm_err_s;
  logic [31:7]       reg_bits_s;
  logic [31:0]       enc_word_s;
  logic              accept_s;
  logic              drain_s;

  logic              valid_d, valid_q;
  logic [31:0]       instr_d, instr_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              err_d, err_q;
  logic              sticky_d, sticky_q;

  assign req_s = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3,
                   funct7: in_funct7, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                   imm: in_imm};

  id_imm_pack u_imm_pack (
    .fmt      (req_s.fmt),
    .imm      (req_s.imm),
    .imm_bits (imm_bits_s),
    .imm_mask (imm_mask_s),
    .imm_err  (imm_err_s)
  );

  assign in_ready = !clr && (!valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  assign drain_s  = valid_q && out_ready;

  // Register-index fields per format; immediate positions are left for imm_bits.
  always_comb begin
    reg_bits_s = 25'd0;
    case (fmt_e'(req_s.fmt))
      FMT_R:        reg_bits_s = {req_s.funct7, req_s.rs2, req_s.rs1, req_s.funct3, req_s.rd};
      FMT_I:        reg_bits_s = {12'd0, req_s.rs1, req_s.funct3, req_s.rd};
      FMT_S, FMT_B: reg_bits_s = {7'd0, req_s.rs2, req_s.rs1, req_s.funct3, 5'd0};
      FMT_U, FMT_J: reg_bits_s = {20'd0, req_s.rd};
      default:      reg_bits_s = 25'd0;
    endcase
  end

  // Final word; an illegal format encodes as all-zero.
  always_comb begin
    if (req_s.fmt > 3'd5) begin
      enc_word_s = 32'd0;
    end else begin
      enc_word_s = {(reg_bits_s & ~imm_mask_s) | imm_bits_s, req_s.opcode};
    end
  end

  // Next-state: clear wins, then drain (address/sticky) and fill can coincide.
  always_comb begin
    valid_d  = valid_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    if (clr) begin
      valid_d  = 1'b0;
      instr_d  = 32'd0;
      addr_d   = {ADDR_W{1'b0}};
      err_d    = 1'b0;
      sticky_d = 1'b0;
    end else begin
      if (drain_s) begin
        addr_d   = addr_q + ADDR_ONE;
        sticky_d = sticky_q | err_q;
        valid_d  = 1'b0;
      end else begin
        addr_d = addr_q;
      end
      if (accept_s) begin
        valid_d = 1'b1;
        instr_d = enc_word_s;
        err_d   = imm_err_s;
      end else begin
        instr_d = instr_q;
      end
    end
  end

  // Output register, address counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      instr_q  <= 32'd0;
      addr_q   <= {ADDR_W{1'b0}};
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_instr  = instr_q;
  assign out_addr   = addr_q;
  assign out_err    = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_id_encoder.sv
// Directed bench for id_encoder: a default-width instance for encoding,
// errors, clear, backpressure and reset, plus an ADDR_W=2 instance for wrap.
module tb_id_encoder;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, out_valid, out_err, err_sticky;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;

  logic        in_ready2, out_valid2, out_err2, err_sticky2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_encoder #(.ADDR_W(10)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky)
  );

  id_encoder #(.ADDR_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_err(out_err2), .err_sticky(err_sticky2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] instr, input logic [9:0] addr,
                          input logic err);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".instr"}, out_instr, instr);
    chk({tag, ".addr"}, {22'd0, out_addr}, {22'd0, addr});
    chk({tag, ".err"}, {31'd0, out_err}, {31'd0, err});
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    #3;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.instr", out_instr, 32'd0);
    chk("rst.addr", {22'd0, out_addr}, 32'd0);
    chk("rst.err", {31'd0, out_err}, 32'd0);
    chk("rst.sticky", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back encodings of every format
    req(3'd0, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk); chk_word("add", 32'h002081b3, 10'd0, 1'b0);
    req(3'd1, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, -32'sd50);
    @(negedge clk); chk_word("addi", 32'hfce30293, 10'd1, 1'b0);
    req(3'd1, OP_LOAD, 3'd2, 7'd0, 5'd7, 5'd8, 5'd0, 32'd16);
    @(negedge clk); chk_word("lw", 32'h01042383, 10'd2, 1'b0);
    req(3'd2, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd10, 5'd9, -32'sd36);
    @(negedge clk); chk_word("sw", 32'hfc952e23, 10'd3, 1'b0);
    req(3'd3, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd11, 5'd12, 32'd4);
    @(negedge clk); chk_word("beq", 32'h00c58263, 10'd4, 1'b0);
    req(3'd4, OP_LUI, 3'd0, 7'd0, 5'd13, 5'd0, 5'd0, 32'hBEEF0000);
    @(negedge clk); chk_word("lui", 32'hbeef06b7, 10'd5, 1'b0);
    req(3'd5, OP_JAL, 3'd0, 7'd0, 5'd14, 5'd0, 5'd0, -32'sd2148);
    @(negedge clk); chk_word("jal", 32'hF9CFF76F, 10'd6, 1'b0);
    chk("sticky.clean", {31'd0, err_sticky}, 32'd0);

    // Unrepresentable immediates and illegal format
    req(3'd1, OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
    @(negedge clk); chk_word("i2048", 32'h80000013, 10'd7, 1'b1);
    chk("sticky.pre", {31'd0, err_sticky}, 32'd0);
    req(3'd3, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    @(negedge clk); chk_word("b3", 32'h00000163, 10'd8, 1'b1);
    chk("sticky.set", {31'd0, err_sticky}, 32'd1);
    req(3'd7, OP_R, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    @(negedge clk); chk_word("fmt7", 32'h00000000, 10'd9, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain.valid", {31'd0, out_valid}, 32'd0);
    chk("drain.addr", {22'd0, out_addr}, 32'd10);

    // Synchronous clear
    clr = 1'b1;
    #1 chk("clr.in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    chk("clr.addr", {22'd0, out_addr}, 32'd0);
    chk("clr.sticky", {31'd0, err_sticky}, 32'd0);
    chk("clr.valid", {31'd0, out_valid}, 32'd0);

    // Backpressure for three cycles with a second word waiting
    out_ready = 1'b0;
    req(3'd0, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk); chk_word("bp.first", 32'h002081b3, 10'd0, 1'b0);
    req(3'd1, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, -32'sd50);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp.in_ready%0d", i), {31'd0, in_ready}, 32'd0);
      @(negedge clk); chk_word($sformatf("bp.hold%0d", i), 32'h002081b3, 10'd0, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk); chk_word("bp.next", 32'hfce30293, 10'd1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp.drain.valid", {31'd0, out_valid}, 32'd0);
    chk("bp.drain.addr", {22'd0, out_addr}, 32'd2);

    // Address wrap on the ADDR_W=2 instance
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(3'd4, OP_LUI, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 32'h00001000);
      @(negedge clk);
      chk($sformatf("wrap.addr%0d", i), {30'd0, out_addr2}, 32'(i % 4));
      chk($sformatf("wrap.wide%0d", i), {22'd0, out_addr}, 32'(i));
      chk($sformatf("wrap.instr%0d", i), out_instr2, 32'h00001037 | (32'(i) << 7));
      chk($sformatf("wrap.valid%0d", i), {31'd0, out_valid2}, 32'd1);
    end

    // Asynchronous reset with a word pending and the sticky flag set
    req(3'd1, OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
    @(negedge clk);
    req(3'd0, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("prerst.valid", {31'd0, out_valid}, 32'd1);
    chk("prerst.sticky", {31'd0, err_sticky}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk("arst.instr", out_instr, 32'd0);
    chk("arst.addr", {22'd0, out_addr}, 32'd0);
    chk("arst.err", {31'd0, out_err}, 32'd0);
    chk("arst.sticky", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req(3'd1, OP_LOAD, 3'd2, 7'd0, 5'd7, 5'd8, 5'd0, 32'd16);
    @(negedge clk); chk_word("postrst", 32'h01042383, 10'd0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
